// File: rtl/regfile_sb.sv
// NUM_REGS x DATA_W register file with a per-register busy scoreboard; reads are combinational, writes and locks take effect on the clock edge.
// There is no backpressure: a denied lock (lock_grant=0) is retried by the requester. Defining REGFILE_BYPASS_EN forwards write data to same-cycle reads.
module regfile_sb #(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [DATA_W-1:0] r_data_a,
  output logic [DATA_W-1:0] r_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              lock_req,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic              lock_grant,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                write_ok;
  logic [DATA_W-1:0]   stored_a;
  logic [DATA_W-1:0]   stored_b;

  // Writes to a hardwired zero register are dropped entirely.
  assign write_ok   = we && !((ZERO_REG != 0) && (w_addr == '0));
  assign lock_grant = lock_req && !busy[lock_addr];
  assign busy_vec   = busy;

  // Release is applied before the lock so that a same-cycle write+lock to an idle register ends up busy.
  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[w_addr] = 1'b0;
    if (lock_grant) busy_nxt[lock_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (write_ok) regs[w_addr] <= w_data;
      busy <= busy_nxt;
    end
  end

  always_comb begin
    stored_a = regs[r_addr_a];
    stored_b = regs[r_addr_b];
    if ((ZERO_REG != 0) && (r_addr_a == '0)) stored_a = '0;
    if ((ZERO_REG != 0) && (r_addr_b == '0)) stored_b = '0;
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  assign fwd_a    = reset_n && write_ok && (r_addr_a == w_addr);
  assign fwd_b    = reset_n && write_ok && (r_addr_b == w_addr);
  assign r_data_a = fwd_a ? w_data : stored_a;
  assign r_data_b = fwd_b ? w_data : stored_b;
  assign busy_a   = fwd_a ? 1'b0 : busy[r_addr_a];
  assign busy_b   = fwd_b ? 1'b0 : busy[r_addr_b];
`else
  assign r_data_a = stored_a;
  assign r_data_b = stored_b;
  assign busy_a   = busy[r_addr_a];
  assign busy_b   = busy[r_addr_b];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a vector table on an ordinary instance plus hand sequences for bypass and the zero-register instance.
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       reset_n, we, lock_req;
  logic [1:0] w_addr, r_addr_a, r_addr_b, lock_addr;
  logic [3:0] w_data, r_data_a, r_data_b, busy_vec;
  logic       busy_a, busy_b, lock_grant;

  logic       z_reset_n, z_we, z_lock_req;
  logic [1:0] z_w_addr, z_r_addr_a, z_r_addr_b, z_lock_addr;
  logic [3:0] z_w_data, z_r_data_a, z_r_data_b, z_busy_vec;
  logic       z_busy_a, z_busy_b, z_lock_grant;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(4), .NUM_REGS(4), .ZERO_REG(0)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .w_addr(w_addr), .w_data(w_data),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(r_data_a), .r_data_b(r_data_b),
    .busy_a(busy_a), .busy_b(busy_b), .lock_req(lock_req), .lock_addr(lock_addr),
    .lock_grant(lock_grant), .busy_vec(busy_vec)
  );

  regfile_sb #(.DATA_W(4), .NUM_REGS(4), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset_n(z_reset_n), .we(z_we), .w_addr(z_w_addr), .w_data(z_w_data),
    .r_addr_a(z_r_addr_a), .r_addr_b(z_r_addr_b), .r_data_a(z_r_data_a), .r_data_b(z_r_data_b),
    .busy_a(z_busy_a), .busy_b(z_busy_b), .lock_req(z_lock_req), .lock_addr(z_lock_addr),
    .lock_grant(z_lock_grant), .busy_vec(z_busy_vec)
  );

  typedef struct packed {
    logic       rst_n;
    logic       we;
    logic [1:0] wa;
    logic [3:0] wd;
    logic       lr;
    logic [1:0] la;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [3:0] e_rda;
    logic [3:0] e_rdb;
    logic       e_ba;
    logic       e_bb;
    logic       e_gnt;
    logic [3:0] e_bvec;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_byp_d;
  logic       exp_byp_b;

  initial begin
    // rst_n we wa wd lr la ra rb | rda rdb ba bb gnt bvec
    tbl[0]  = '{1'b1,1'b0,2'd0,4'h0,1'b0,2'd0,2'd0,2'd1, 4'h0,4'h0,1'b0,1'b0,1'b0,4'b0000};
    tbl[1]  = '{1'b1,1'b1,2'd2,4'hA,1'b0,2'd0,2'd0,2'd1, 4'h0,4'h0,1'b0,1'b0,1'b0,4'b0000};
    tbl[2]  = '{1'b1,1'b0,2'd0,4'h0,1'b0,2'd0,2'd2,2'd2, 4'hA,4'hA,1'b0,1'b0,1'b0,4'b0000};
    tbl[3]  = '{1'b0,1'b1,2'd3,4'h5,1'b1,2'd1,2'd2,2'd0, 4'hA,4'h0,1'b0,1'b0,1'b1,4'b0000};
    tbl[4]  = '{1'b1,1'b0,2'd0,4'h0,1'b0,2'd0,2'd2,2'd3, 4'h0,4'h0,1'b0,1'b0,1'b0,4'b0000};
    tbl[5]  = '{1'b1,1'b0,2'd0,4'h0,1'b1,2'd1,2'd1,2'd0, 4'h0,4'h0,1'b0,1'b0,1'b1,4'b0000};
    tbl[6]  = '{1'b1,1'b0,2'd0,4'h0,1'b1,2'd1,2'd1,2'd0, 4'h0,4'h0,1'b1,1'b0,1'b0,4'b0010};
    tbl[7]  = '{1'b1,1'b1,2'd1,4'h5,1'b0,2'd0,2'd0,2'd2, 4'h0,4'h0,1'b0,1'b0,1'b0,4'b0010};
    tbl[8]  = '{1'b1,1'b0,2'd0,4'h0,1'b0,2'd0,2'd1,2'd1, 4'h5,4'h5,1'b0,1'b0,1'b0,4'b0000};
    tbl[9]  = '{1'b1,1'b0,2'd0,4'h0,1'b1,2'd3,2'd3,2'd0, 4'h0,4'h0,1'b0,1'b0,1'b1,4'b0000};
    tbl[10] = '{1'b1,1'b1,2'd3,4'h7,1'b1,2'd3,2'd0,2'd1, 4'h0,4'h5,1'b0,1'b0,1'b0,4'b1000};
    tbl[11] = '{1'b1,1'b0,2'd0,4'h0,1'b1,2'd3,2'd3,2'd1, 4'h7,4'h5,1'b0,1'b0,1'b1,4'b0000};
    tbl[12] = '{1'b1,1'b0,2'd0,4'h0,1'b0,2'd0,2'd3,2'd3, 4'h7,4'h7,1'b1,1'b1,1'b0,4'b1000};
    tbl[13] = '{1'b1,1'b1,2'd2,4'h6,1'b1,2'd2,2'd3,2'd1, 4'h7,4'h5,1'b1,1'b0,1'b1,4'b1000};
    tbl[14] = '{1'b1,1'b0,2'd0,4'h0,1'b0,2'd0,2'd2,2'd3, 4'h6,4'h7,1'b1,1'b1,1'b0,4'b1100};
    tbl[15] = '{1'b1,1'b1,2'd3,4'h8,1'b1,2'd0,2'd2,2'd1, 4'h6,4'h5,1'b1,1'b0,1'b1,4'b1100};
    tbl[16] = '{1'b1,1'b0,2'd0,4'h0,1'b0,2'd0,2'd3,2'd0, 4'h8,4'h0,1'b0,1'b1,1'b0,4'b0101};
    tbl[17] = '{1'b1,1'b1,2'd0,4'h3,1'b0,2'd0,2'd2,2'd1, 4'h6,4'h5,1'b1,1'b0,1'b0,4'b0101};
    tbl[18] = '{1'b1,1'b1,2'd1,4'hC,1'b0,2'd0,2'd2,2'd3, 4'h6,4'h8,1'b1,1'b0,1'b0,4'b0100};
    tbl[19] = '{1'b1,1'b0,2'd0,4'h0,1'b0,2'd0,2'd0,2'd1, 4'h3,4'hC,1'b0,1'b0,1'b0,4'b0100};
    tbl[20] = '{1'b1,1'b0,2'd0,4'h0,1'b0,2'd0,2'd1,2'd1, 4'hC,4'hC,1'b0,1'b0,1'b0,4'b0100};
    tbl[21] = '{1'b0,1'b0,2'd0,4'h0,1'b0,2'd0,2'd2,2'd0, 4'h6,4'h3,1'b1,1'b0,1'b0,4'b0100};
    tbl[22] = '{1'b1,1'b0,2'd0,4'h0,1'b0,2'd0,2'd2,2'd1, 4'h0,4'h0,1'b0,1'b0,1'b0,4'b0000};

    reset_n = 1'b0; we = 1'b0; w_addr = 2'd0; w_data = 4'h0;
    lock_req = 1'b0; lock_addr = 2'd0; r_addr_a = 2'd0; r_addr_b = 2'd0;
    z_reset_n = 1'b0; z_we = 1'b0; z_w_addr = 2'd0; z_w_data = 4'h0;
    z_lock_req = 1'b0; z_lock_addr = 2'd0; z_r_addr_a = 2'd0; z_r_addr_b = 2'd0;
    tick();
    tick();
    reset_n = 1'b1;
    z_reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      reset_n = tbl[i].rst_n; we = tbl[i].we; w_addr = tbl[i].wa; w_data = tbl[i].wd;
      lock_req = tbl[i].lr; lock_addr = tbl[i].la; r_addr_a = tbl[i].ra; r_addr_b = tbl[i].rb;
      @(negedge clk);
      chk($sformatf("v%0d r_data_a", i), 32'(r_data_a), 32'(tbl[i].e_rda));
      chk($sformatf("v%0d r_data_b", i), 32'(r_data_b), 32'(tbl[i].e_rdb));
      chk($sformatf("v%0d busy_a", i), 32'(busy_a), 32'(tbl[i].e_ba));
      chk($sformatf("v%0d busy_b", i), 32'(busy_b), 32'(tbl[i].e_bb));
      chk($sformatf("v%0d lock_grant", i), 32'(lock_grant), 32'(tbl[i].e_gnt));
      chk($sformatf("v%0d busy_vec", i), 32'(busy_vec), 32'(tbl[i].e_bvec));
      tick();
    end
    reset_n = 1'b1; we = 1'b0; lock_req = 1'b0;

`ifdef REGFILE_BYPASS_EN
    exp_byp_d = 4'h9;
    exp_byp_b = 1'b0;
`else
    exp_byp_d = 4'h0;
    exp_byp_b = 1'b1;
`endif
    // Reserve r2, then write it back while reading it in the same cycle.
    lock_req = 1'b1; lock_addr = 2'd2;
    tick();
    lock_req = 1'b0;
    we = 1'b1; w_addr = 2'd2; w_data = 4'h9; r_addr_a = 2'd2; r_addr_b = 2'd2;
    @(negedge clk);
    chk("bypass r_data_a", 32'(r_data_a), 32'(exp_byp_d));
    chk("bypass r_data_b", 32'(r_data_b), 32'(exp_byp_d));
    chk("bypass busy_a", 32'(busy_a), 32'(exp_byp_b));
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("post-write r_data_a", 32'(r_data_a), 32'h9);
    chk("post-write busy_a", 32'(busy_a), 32'h0);
    tick();
    // Forwarding must not leak through while reset is held.
    reset_n = 1'b0; we = 1'b1; w_addr = 2'd1; w_data = 4'h4; r_addr_a = 2'd1;
    @(negedge clk);
    chk("bypass in reset r_data_a", 32'(r_data_a), 32'h0);
    tick();
    reset_n = 1'b1; we = 1'b0;
    @(negedge clk);
    chk("reset after bypass r_data_a", 32'(r_data_a), 32'h0);
    chk("reset after bypass r2", 32'(r_data_b), 32'h0);

    // Hardwired zero register.
    tick();
    z_we = 1'b1; z_w_addr = 2'd0; z_w_data = 4'hF; z_lock_req = 1'b1; z_lock_addr = 2'd0;
    z_r_addr_a = 2'd0; z_r_addr_b = 2'd1;
    @(negedge clk);
    chk("zero lock_grant", 32'(z_lock_grant), 32'h1);
    chk("zero r_data_a same cycle", 32'(z_r_data_a), 32'h0);
    chk("zero busy_a same cycle", 32'(z_busy_a), 32'h0);
    tick();
    z_we = 1'b1; z_w_addr = 2'd1; z_w_data = 4'hF; z_lock_req = 1'b1; z_lock_addr = 2'd0;
    @(negedge clk);
    chk("zero r_data_a after write", 32'(z_r_data_a), 32'h0);
    chk("zero busy_vec after lock", 32'(z_busy_vec), 32'h0);
    chk("zero relock grant", 32'(z_lock_grant), 32'h1);
    tick();
    z_we = 1'b0; z_lock_req = 1'b0;
    @(negedge clk);
    chk("zero r1 ordinary", 32'(z_r_data_b), 32'hF);
    chk("zero r0 still zero", 32'(z_r_data_a), 32'h0);
    chk("zero busy_vec final", 32'(z_busy_vec), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
